// File: rtl/md_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// master = pipeline side (issues ops), slave = md_unit.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, flush,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, flush,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO for the EX stage.
// Single-op-in-flight design: an accepted op latches its operands and the
// current {HI,LO}, then a down-counter models the configured latency. The
// result is formed from the latched copies and written when the counter
// expires, so forwarding changes on a/b after accept cannot leak in.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam int W2      = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2-1:0]    hl_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic             is_signed;
  logic [W2-1:0]    ea, eb, prod, res;
  logic signed [WIDTH-1:0] sa, sb, sq, sr;
  logic [WIDTH-1:0] uq, ur;
  logic             ovf;

  // Result of the latched op; only consumed on the completing edge.
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    ea   = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    eb   = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product are the exact signed or
    // unsigned product, so one multiplier serves both flavours.
    prod = ea * eb;
    sa   = $signed(a_q);
    sb   = $signed(b_q);
    // Divide-by-zero and overflow are steered away from the dividers below.
    sq   = sa / sb;
    sr   = sa % sb;
    uq   = a_q / b_q;
    ur   = a_q % b_q;
    ovf  = (a_q == MOST_NEG) && (b_q == {WIDTH{1'b1}});
    res  = hl_q;
    case (op_q)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD, OP_MADDU: res = hl_q + prod;
      OP_MSUB, OP_MSUBU: res = hl_q - prod;
      OP_DIV: begin
        if (b_q == '0)  res = {a_q, {WIDTH{1'b1}}};
        else if (ovf)   res = {{WIDTH{1'b0}}, a_q};
        else            res = {sr, sq};
      end
      OP_DIVU: begin
        if (b_q == '0)  res = {a_q, {WIDTH{1'b1}}};
        else            res = {ur, uq};
      end
      default: res = hl_q;
    endcase
  end

  // Control FSM plus HI/LO; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hl_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
              OP_DIV, OP_DIVU: begin
                state  <= RUN;
                busy_q <= 1'b1;
                op_q   <= bus.op;
                a_q    <= bus.a;
                b_q    <= bus.b;
                hl_q   <= {hi_q, lo_q};
                cnt    <= ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ?
                          CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            {hi_q, lo_q} <= res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed + randomised bench for md_unit: a 32-bit default instance and an
// 8-bit short-latency instance, results checked through per-instance
// scoreboards fed by an independent 64-bit reference model.
module tb_md_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_if #(.WIDTH(32)) m32 ();
  md_if #(.WIDTH(8))  m8 ();

  md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut32 (
    .clk(clk), .reset(reset), .bus(m32));
  md_unit #(.WIDTH(8), .MUL_LAT(1), .DIV_LAT(3)) dut8 (
    .clk(clk), .reset(reset), .bus(m8));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp32[$];
  logic [15:0] exp8[$];
  logic [31:0] mh32 = '0, ml32 = '0;
  logic [7:0]  mh8 = '0, ml8 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op, input int ml, input int dl);
    if (op inside {4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10}) return ml;
    if (op inside {4'd3, 4'd4}) return dl;
    return 0;
  endfunction

  // Reference model in 64-bit integers for widths up to 32.
  function automatic logic [63:0] model(input int w, input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] m1, m2, ua, ub, hl, p, res;
    longint sa, sb, q, r;
    bit sgn;
    m1  = (64'd1 << w) - 64'd1;
    m2  = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ua  = {32'd0, a} & m1;
    ub  = {32'd0, b} & m1;
    sa  = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb  = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    hl  = ((({32'd0, hi}) & m1) << w) | ({32'd0, lo} & m1);
    sgn = op inside {4'd1, 4'd3, 4'd7, 4'd9};
    if (sgn) p = sa * sb;
    else     p = ua * ub;
    case (op)
      4'd1, 4'd2:  res = p;
      4'd7, 4'd8:  res = hl + p;
      4'd9, 4'd10: res = hl - p;
      4'd3, 4'd4: begin
        if (ub == 0) res = (ua << w) | m1;
        else if (sgn) begin
          q = sa / sb; r = sa % sb;
          res = ((r & m1) << w) | (q & m1);
        end else
          res = (((ua % ub) & m1) << w) | ((ua / ub) & m1);
      end
      4'd5:    res = (ua << w) | (hl & m1);
      4'd6:    res = (hl & ~m1) | ua;
      default: res = hl;
    endcase
    return res & m2;
  endfunction

  task automatic do32(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit hold);
    int lat, n;
    logic [63:0] e;
    lat = lat_of(op, 5, 10);
    @(negedge clk);
    m32.start = 1'b1; m32.op = op; m32.a = a; m32.b = b;
    e = model(32, op, a, b, mh32, ml32);
    if (lat > 0) exp32.push_back(e);
    {mh32, ml32} = e;
    @(negedge clk);
    if (!hold) m32.start = 1'b0;
    m32.a = ~a; m32.b = ~b;
    if (lat == 0) begin
      chk("mt_hilo", {m32.hi, m32.lo}, e);
      chk("mt_busy", 64'(m32.busy), 64'd0);
      chk("mt_done", 64'(m32.done), 64'd0);
      return;
    end
    n = 0;
    while (m32.busy === 1'b1 && n < 40) begin
      if (m32.done !== 1'b0) chk("done_early", 64'(m32.done), 64'd0);
      n++;
      @(negedge clk);
    end
    m32.start = 1'b0;
    chk("busy_cycles", 64'(n), 64'(lat));
    chk("done_pulse", 64'(m32.done), 64'd1);
    if (exp32.size() > 0) chk("hilo", {m32.hi, m32.lo}, exp32.pop_front());
    else chk("sb_empty", 64'(exp32.size()), 64'd1);
    @(negedge clk);
    chk("done_once", 64'(m32.done), 64'd0);
    chk("busy_after", 64'(m32.busy), 64'd0);
  endtask

  task automatic do8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int lat, n;
    logic [63:0] e;
    lat = lat_of(op, 1, 3);
    @(negedge clk);
    m8.start = 1'b1; m8.op = op; m8.a = a; m8.b = b;
    e = model(8, op, {24'd0, a}, {24'd0, b}, {24'd0, mh8}, {24'd0, ml8});
    if (lat > 0) exp8.push_back(e[15:0]);
    {mh8, ml8} = e[15:0];
    @(negedge clk);
    m8.start = 1'b0; m8.a = ~a; m8.b = ~b;
    if (lat == 0) begin
      chk("w8_mt_hilo", 64'({m8.hi, m8.lo}), 64'(e[15:0]));
      chk("w8_mt_busy", 64'(m8.busy), 64'd0);
      return;
    end
    n = 0;
    while (m8.busy === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("w8_busy_cycles", 64'(n), 64'(lat));
    chk("w8_done", 64'(m8.done), 64'd1);
    if (exp8.size() > 0) chk("w8_hilo", 64'({m8.hi, m8.lo}), 64'(exp8.pop_front()));
    else chk("w8_sb_empty", 64'(exp8.size()), 64'd1);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] sp[4] = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    m32.start = 0; m32.op = 0; m32.a = 0; m32.b = 0; m32.flush = 0;
    m8.start = 0;  m8.op = 0;  m8.a = 0;  m8.b = 0;  m8.flush = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(m32.hi), 64'd0);
    chk("rst_lo", 64'(m32.lo), 64'd0);
    chk("rst_busy", 64'(m32.busy), 64'd0);
    chk("rst_done", 64'(m32.done), 64'd0);
    reset = 1'b1;

    do32(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_const", {m32.hi, m32.lo}, 64'hFFFFFFFF_FFFFFFFA);

    do32(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_const", {m32.hi, m32.lo}, 64'h00000001_FFFFFFFE);
    do32(4'd8, 32'd1, 32'd1, 1'b1);
    chk("maddu_const", {m32.hi, m32.lo}, 64'h00000001_FFFFFFFF);

    do32(4'd3, -32'sd7, 32'd2, 1'b0);
    chk("div_const", {m32.hi, m32.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do32(4'd4, 32'd7, 32'd0, 1'b0);
    chk("divu0_const", {m32.hi, m32.lo}, 64'h00000007_FFFFFFFF);

    do32(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("ovf_const", {m32.hi, m32.lo}, 64'h00000000_80000000);
    do32(4'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_const", 64'(m32.hi), 64'h1234);

    // Codes outside 1..10 and a flushed start must leave HI/LO alone.
    do32(4'd11, 32'hDEAD, 32'd1, 1'b0);
    do32(4'd0, 32'hBEEF, 32'd1, 1'b0);
    @(negedge clk);
    m32.start = 1'b1; m32.op = 4'd1; m32.a = 32'd9; m32.b = 32'd9; m32.flush = 1'b1;
    @(negedge clk);
    m32.start = 1'b0; m32.flush = 1'b0;
    chk("flush_blocks_accept", 64'(m32.busy), 64'd0);
    chk("flush_idle_hilo", {m32.hi, m32.lo}, {mh32, ml32});

    // Flush in the 4th busy cycle of a divide.
    do32(4'd5, 32'd5, 32'd0, 1'b0);
    do32(4'd6, 32'd6, 32'd0, 1'b0);
    @(negedge clk);
    m32.start = 1'b1; m32.op = 4'd3; m32.a = 32'd100; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 1'b0;
    repeat (3) @(negedge clk);
    m32.flush = 1'b1;
    @(negedge clk);
    m32.flush = 1'b0;
    chk("flush_busy", 64'(m32.busy), 64'd0);
    chk("flush_done", 64'(m32.done), 64'd0);
    chk("flush_hilo", {m32.hi, m32.lo}, 64'h00000005_00000006);
    @(negedge clk);
    chk("flush_done_late", 64'(m32.done), 64'd0);
    chk("flush_hilo_late", {m32.hi, m32.lo}, 64'h00000005_00000006);

    // Same, but reset mid-op.
    @(negedge clk);
    m32.start = 1'b1; m32.op = 4'd3; m32.a = 32'd100; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mh32 = '0; ml32 = '0; mh8 = '0; ml8 = '0;
    chk("rst_mid_hilo", {m32.hi, m32.lo}, 64'd0);
    chk("rst_mid_busy", 64'(m32.busy), 64'd0);
    @(negedge clk);
    chk("rst_mid_done", 64'(m32.done), 64'd0);

    // Narrow instance: directed msub, then randomised sweep.
    do8(4'd9, 8'h7F, 8'h7F);
    chk("w8_msub_const", 64'({m8.hi, m8.lo}), 64'hC0FF);
    for (int i = 0; i < 10000; i++)
      do8(4'($urandom_range(0, 15)), pick8(), pick8());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
